// File: rtl/arbiter_pkg.sv
// Shared helpers for the switch-allocator arbiters: sizing, FSM encoding and
// one-hot to binary conversion.
package arbiter_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Index width for n requesters; never below 1 so a 2-way arbiter still has a bit.
  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int one_hot_to_bin(input logic [31:0] oh);
    int b;
    b = 0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) b = b | i;
    return b;
  endfunction

endpackage

// File: rtl/wrr_packet_arbiter_rr_pick.sv
// Pointer-based one-hot picker: first set request at or above ptr, wrapping.
module wrr_rr_pick
  import arbiter_pkg::*;
#(
  parameter int W  = 4,
  parameter int PW = log2(W)
) (
  input  logic [W-1:0]  request,
  input  logic [PW-1:0] ptr,
  output logic [W-1:0]  grant
);

  logic [W-1:0]   mask;
  logic [2*W-1:0] dbl;
  logic [2*W-1:0] dbl_gnt;

  // Lower half holds requests at/above ptr, upper half the full vector, so the
  // lowest set bit of the concatenation is the wrapped round-robin winner.
  assign mask    = ~((W'(1) << ptr) - W'(1));
  assign dbl     = {request, request & mask};
  assign dbl_gnt = dbl & ~(dbl - (2*W)'(1));
  assign grant   = dbl_gnt[W-1:0] | dbl_gnt[2*W-1:W];

endmodule

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin output-port arbiter that holds a grant from head to
// tail flit and lets each requester send up to its weight in packets per turn.
module wrr_packet_arbiter
  import arbiter_pkg::*;
#(
  parameter int ARBITER_WIDTH = 4,
  parameter int WEIGHT_WIDTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [ARBITER_WIDTH-1:0]              request,
  input  logic [ARBITER_WIDTH-1:0]              tail,
  input  logic [ARBITER_WIDTH*WEIGHT_WIDTH-1:0] weight,
  input  logic                                  ready,
  output logic [ARBITER_WIDTH-1:0]              grant,
  output logic                                  any_grant,
  output logic                                  locked,
  output logic [log2(ARBITER_WIDTH)-1:0]        owner
);

  localparam int AW = ARBITER_WIDTH;
  localparam int WW = WEIGHT_WIDTH;
  localparam int PW = log2(ARBITER_WIDTH);

  logic [0:0]    state, state_n;
  logic [PW-1:0] ptr, ptr_n, owner_n, g, g_nxt;
  logic [WW-1:0] pkt_cnt, cnt_n, base, w_eff;
  logic [AW-1:0] idle_grant;
  logic [WW-1:0] wt [AW];
  logic          xfer;
  logic          quota_done;

  for (genvar i = 0; i < AW; i++) begin : g_wt
    assign wt[i] = weight[i*WW +: WW];
  end

  wrr_rr_pick #(.W(AW), .PW(PW)) u_pick (
    .request (request),
    .ptr     (ptr),
    .grant   (idle_grant)
  );

  always_comb begin
    grant = idle_grant;
    g     = PW'(one_hot_to_bin(32'(idle_grant)));
    if (state == ST_LOCKED) begin
      grant = (AW'(1) << owner) & request;
      g     = owner;
    end
  end

  assign any_grant = |grant;
  assign xfer      = any_grant & ready;
  assign locked    = (state == ST_LOCKED);

  // A different winner in IDLE starts a fresh quota.
  assign base       = (state == ST_IDLE && g != owner) ? '0 : pkt_cnt;
  assign w_eff      = (wt[g] == '0) ? WW'(1) : wt[g];
  assign quota_done = ({1'b0, base} + (WW+1)'(1)) >= {1'b0, w_eff};
  assign g_nxt      = (g == PW'(AW-1)) ? '0 : g + PW'(1);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = pkt_cnt;
    if (xfer) begin
      owner_n = g;
      if (tail[g]) begin
        state_n = ST_IDLE;
        if (quota_done) begin
          ptr_n = g_nxt;
          cnt_n = '0;
        end else begin
          ptr_n = g;
          cnt_n = base + WW'(1);
        end
      end else begin
        state_n = ST_LOCKED;
        cnt_n   = base;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      owner   <= '0;
      pkt_cnt <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      pkt_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Scoreboard bench: a 4-way and a 3-way (all-zero weight) arbiter share stimulus
// and are checked each cycle against a queue-fed behavioural model.
module tb_wrr_packet_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  request = '0;
  logic [3:0]  tail = '0;
  logic        ready = 1'b0;
  logic [15:0] weight0 = 16'h1111;
  logic [11:0] weight1 = '0;
  logic [15:0] w0_pending = 16'h1111;

  logic [3:0]  grant0;
  logic        any0, locked0;
  logic [1:0]  owner0;
  logic [2:0]  grant1;
  logic        any1, locked1;
  logic [1:0]  owner1;

  wrr_packet_arbiter #(.ARBITER_WIDTH(4), .WEIGHT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .request(request), .tail(tail), .weight(weight0),
    .ready(ready), .grant(grant0), .any_grant(any0), .locked(locked0), .owner(owner0));

  wrr_packet_arbiter #(.ARBITER_WIDTH(3), .WEIGHT_WIDTH(4)) u_dut3 (
    .clk(clk), .reset(reset), .request(request[2:0]), .tail(tail[2:0]), .weight(weight1),
    .ready(ready), .grant(grant1), .any_grant(any1), .locked(locked1), .owner(owner1));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g0;
    logic [2:0] g1;
    logic       l0, l1;
    logic [1:0] o0, o1;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Model state per instance: 0 = 4-way, 1 = 3-way.
  bit m_locked [2];
  int m_owner  [2];
  int m_ptr    [2];
  int m_cnt    [2];

  function automatic int m_n(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int m_weight(input int k, input int idx);
    int w;
    w = (k == 0) ? int'(weight0 >> (idx*4)) & 15 : int'(weight1 >> (idx*4)) & 15;
    return (w == 0) ? 1 : w;
  endfunction

  // Index of the requester that wins this cycle, -1 if none.
  function automatic int m_pick(input int k, input logic [3:0] rq);
    int idx;
    if (m_locked[k]) return rq[m_owner[k]] ? m_owner[k] : -1;
    for (int i = 0; i < m_n(k); i++) begin
      idx = (m_ptr[k] + i) % m_n(k);
      if (rq[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_locked[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_clock();
    int g;
    for (int k = 0; k < 2; k++) begin
      g = m_pick(k, request);
      if (ready && g >= 0) begin
        if (!m_locked[k] && g != m_owner[k]) m_cnt[k] = 0;
        m_owner[k] = g;
        if (tail[g]) begin
          m_locked[k] = 0;
          if (m_cnt[k] + 1 >= m_weight(k, g)) begin
            m_ptr[k] = (g + 1) % m_n(k);
            m_cnt[k] = 0;
          end else begin
            m_ptr[k] = g;
            m_cnt[k] = m_cnt[k] + 1;
          end
        end else begin
          m_locked[k] = 1;
        end
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    int g;
    g = m_pick(0, request);
    e.g0 = (g < 0) ? 4'd0 : 4'(1 << g);
    g = m_pick(1, request);
    e.g1 = (g < 0) ? 3'd0 : 3'(1 << g);
    e.l0 = m_locked[0];
    e.l1 = m_locked[1];
    e.o0 = 2'(m_owner[0]);
    e.o1 = 2'(m_owner[1]);
    q.push_back(e);
  endtask

  task automatic step(input logic [3:0] rq, input logic [3:0] tl, input logic rd);
    @(posedge clk); #1;
    reset   = 1'b0;
    weight0 = w0_pending;
    request = rq;
    tail    = tl;
    ready   = rd;
    push_expect();
    model_clock();
  endtask

  // Reset is raised mid-cycle; the check lands before any further clock edge.
  task automatic apply_reset(input logic [3:0] rq);
    @(posedge clk); #1;
    request = rq;
    tail    = '0;
    ready   = 1'b1;
    reset   = 1'b1;
    model_reset();
    push_expect();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("grant4",     32'(grant0),  32'(e.g0));
      chk("any_grant4", 32'(any0),    32'(|e.g0));
      chk("locked4",    32'(locked0), 32'(e.l0));
      chk("owner4",     32'(owner0),  32'(e.o0));
      chk("grant3",     32'(grant1),  32'(e.g1));
      chk("any_grant3", 32'(any1),    32'(|e.g1));
      chk("locked3",    32'(locked1), 32'(e.l1));
      chk("owner3",     32'(owner1),  32'(e.o1));
    end
  end

  initial begin
    logic [3:0] rq, tl, om;
    model_reset();
    apply_reset(4'b1111);

    // Single-flit packets, unit weights: plain rotation.
    repeat (5) step(4'b1111, 4'b1111, 1'b1);

    // Three-flit packet from req0 while req1 keeps asking.
    apply_reset(4'b0011);
    step(4'b0011, 4'b0000, 1'b1);
    step(4'b0011, 4'b0000, 1'b1);
    step(4'b0011, 4'b0001, 1'b1);
    step(4'b0010, 4'b0010, 1'b1);

    // Weight 3 on requester 0.
    apply_reset(4'b1111);
    w0_pending = 16'h1113;
    repeat (10) step(4'b1111, 4'b1111, 1'b1);

    // Stall then owner gap mid-packet.
    w0_pending = 16'h1111;
    step(4'b0111, 4'b0000, 1'b1);
    om = 4'(1 << m_owner[0]);
    step(4'b0111, 4'b1111, 1'b0);
    step(4'b0111, 4'b1111, 1'b0);
    step(4'b0111 & ~om, 4'b1111, 1'b1);
    step(4'b0111, 4'b0000, 1'b1);
    step(4'b0111, om, 1'b1);
    step(4'b0111, 4'b1111, 1'b1);

    // Lock owner 2, then reset while locked.
    step(4'b0100, 4'b0000, 1'b1);
    step(4'b1111, 4'b0000, 1'b1);
    apply_reset(4'b1111);
    repeat (4) step(4'b0111, 4'b0111, 1'b1);

    // Random traffic with occasional weight changes and resets.
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0)
        w0_pending = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                      4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      rq = 4'($urandom);
      tl = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 249) == 0) apply_reset(rq);
      else step(rq, tl, $urandom_range(0, 3) != 0);
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
